// File: rtl/call_scheduler_pkg.sv
// call_scheduler_pkg: shared FSM encoding, floor count and target-selection helper
package call_scheduler_pkg;

   localparam int NFLOORS = 3;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      SELECT   = 2'b01,
      DISPATCH = 2'b10,
      WAIT     = 2'b11
   } state_t;

   typedef struct packed {
      logic [1:0] tgt;
      logic       up;
   } sel_t;

   // Current floor wins, then the nearest call in the scan direction,
   // otherwise reverse and take the nearest call the other way.
   function automatic sel_t select_target(logic [2:0] pend, logic [1:0] flr, logic up);
      sel_t s;
      logic [3:0] p4;
      logic [1:0] above, below;
      logic has_a, has_b;
      p4 = {1'b0, pend};
      above = flr;
      below = flr;
      has_a = 1'b0;
      has_b = 1'b0;
      for (int i = NFLOORS - 1; i >= 0; i--)
         if (pend[i] && i > int'(flr)) begin
            has_a = 1'b1;
            above = i[1:0];
         end
      for (int i = 0; i < NFLOORS; i++)
         if (pend[i] && i < int'(flr)) begin
            has_b = 1'b1;
            below = i[1:0];
         end
      s.tgt = p4[flr] ? flr :
              up      ? (has_a ? above : has_b ? below : flr) :
                        (has_b ? below : has_a ? above : flr);
      s.up  = p4[flr] ? up :
              up      ? (has_a ? 1'b1 : has_b ? 1'b0 : up) :
                        (has_b ? 1'b0 : has_a ? 1'b1 : up);
      return s;
   endfunction

endpackage

// File: rtl/call_scheduler_if.sv
// call_scheduler_if: scheduler <-> car controller handshake
// master (scheduler): drives Go, Tgt, Up, R; samples Done, DoorOpen
// slave  (car side) : drives Done, DoorOpen; samples Go, Tgt, Up, R
interface call_scheduler_if;
   logic       Go;
   logic [1:0] Tgt;
   logic       Up;
   logic       R;
   logic       Done;
   logic       DoorOpen;
   modport master(output Go, Tgt, Up, R, input Done, DoorOpen);
   modport slave(input Go, Tgt, Up, R, output Done, DoorOpen);
endinterface

// File: rtl/call_scheduler_door_timer.sv
// door_timer: door dwell counter, R asserts DOOR_TICKS edges after DoorOpen rises
// Ports: Clk, Reset (async, active-low), DoorOpen in, R out (dwell expired)
module door_timer #(
   parameter int DOOR_TICKS = 8
) (
   input  logic Clk,
   input  logic Reset,
   input  logic DoorOpen,
   output logic R
);
   localparam logic [7:0] LOAD = 8'(DOOR_TICKS - 1);
   logic       door_q;
   logic       rise;
   logic [7:0] cnt, cnt_n;
   // Counter saturates at zero and only moves while the door is open.
   always_comb begin
      rise  = DoorOpen & ~door_q;
      cnt_n = rise ? LOAD : (DoorOpen && cnt != 8'd0) ? cnt - 8'd1 : cnt;
   end
   always_ff @(posedge Clk or negedge Reset)
      if (!Reset) begin
         door_q <= 1'b0;
         cnt    <= 8'd0;
         R      <= 1'b0;
      end else begin
         door_q <= DoorOpen;
         cnt    <= cnt_n;
         R      <= DoorOpen && cnt_n == 8'd0;
      end
endmodule

// File: rtl/call_scheduler.sv
// call_scheduler: latches floor calls, picks the next target and dispatches the car
// Ports: Clk, Reset (async, active-low), I0..I2 cabin buttons, E0..E2 hall buttons,
//        S0..S2 floor sensors, Pend call lamps, car (handshake: Go/Tgt/Up/R/Done/DoorOpen)
module call_scheduler
   import call_scheduler_pkg::*;
#(
   parameter int DOOR_TICKS = 8
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       I0, I1, I2,
   input  logic       E0, E1, E2,
   input  logic       S0, S1, S2,
   output logic [2:0] Pend,
   call_scheduler_if.master car
);
   state_t     state, nxt;
   logic [2:0] pend, press, sens, clr;
   logic [1:0] flr, tgt;
   logic       up;
   sel_t       sel;
   assign press = {I2 | E2, I1 | E1, I0 | E0};
   assign sens  = {S2, S1, S0};
   assign sel   = select_target(pend, flr, up);
   // Done only counts in WAIT; the clear beats a same-cycle press of Tgt.
   assign clr   = (state == WAIT && car.Done) ? 3'b001 << tgt : 3'b000;
   always_comb begin
      nxt    = state;
      car.Go = 1'b0;
      case (state)
         IDLE:     nxt = |pend ? SELECT : IDLE;
         SELECT:   nxt = DISPATCH;
         DISPATCH: begin
            nxt    = WAIT;
            car.Go = 1'b1;
         end
         WAIT:     begin
            nxt    = car.Done ? IDLE : WAIT;
            car.Go = 1'b1;
         end
      endcase
   end
   always_ff @(posedge Clk or negedge Reset)
      if (!Reset) begin
         state <= IDLE;
         pend  <= 3'b000;
         flr   <= 2'd0;
         tgt   <= 2'd0;
         up    <= 1'b1;
      end else begin
         state <= nxt;
         pend  <= (pend | press) & ~clr;
         if ($onehot(sens)) flr <= sens[2] ? 2'd2 : sens[1] ? 2'd1 : 2'd0;
         if (state == SELECT) begin
            tgt <= sel.tgt;
            up  <= sel.up;
         end
      end
   assign Pend    = pend;
   assign car.Tgt = tgt;
   assign car.Up  = up;
   door_timer #(.DOOR_TICKS(DOOR_TICKS)) u_timer (
      .Clk      (Clk),
      .Reset    (Reset),
      .DoorOpen (car.DoorOpen),
      .R        (car.R)
   );
endmodule

// File: tb/tb_call_scheduler.sv
// tb_call_scheduler: directed stimulus with a dispatch scoreboard and direct state checks
module tb_call_scheduler;
   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       I0 = 0, I1 = 0, I2 = 0, E0 = 0, E1 = 0, E2 = 0, S0 = 0, S1 = 0, S2 = 0;
   logic [2:0] Pend;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [2:0] exp_q[$];
   logic       go_q = 1'b0;

   call_scheduler_if car();

   call_scheduler #(.DOOR_TICKS(8)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .I0    (I0), .I1(I1), .I2(I2),
      .E0    (E0), .E1(E1), .E2(E2),
      .S0    (S0), .S1(S1), .S2(S2),
      .Pend  (Pend),
      .car   (car.master)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   // expected dispatch encoded as {tgt, up}
   task automatic expect_go(input logic [1:0] t, input logic u);
      exp_q.push_back({t, u});
   endtask

   task automatic serve();
      int n = 0;
      while (!car.Go && n < 20) begin
         tick(1);
         n++;
      end
      if (!car.Go) chk("go_timeout", 0, 1);
      tick(1);
      car.Done = 1'b1;
      tick(1);
      car.Done = 1'b0;
   endtask

   // Monitor: every Go rising edge must match the next queued dispatch.
   always @(negedge Clk) begin
      if (car.Go && !go_q) begin
         if (exp_q.size() == 0) chk("unexpected_dispatch", 1, 0);
         else begin
            logic [2:0] e;
            e = exp_q.pop_front();
            chk("dispatch_tgt", int'(car.Tgt), int'(e[2:1]));
            chk("dispatch_up", int'(car.Up), int'(e[0]));
         end
      end
      go_q = car.Go;
   end

   initial begin
      car.Done = 1'b0;
      car.DoorOpen = 1'b0;
      #2 Reset = 1'b0;
      #1;
      chk("rst_go", int'(car.Go), 0);
      chk("rst_pend", int'(Pend), 0);
      chk("rst_tgt", int'(car.Tgt), 0);
      chk("rst_up", int'(car.Up), 1);
      chk("rst_r", int'(car.R), 0);
      tick(2);
      Reset = 1'b1;
      // basic hall call from floor 0 to floor 2
      S0 = 1;
      E2 = 1;
      tick(1);
      E2 = 0;
      chk("t1_pend", int'(Pend), 3'b100);
      expect_go(2'd2, 1'b1);
      tick(1);
      chk("t1_go_early", int'(car.Go), 0);
      tick(1);
      chk("t1_go_latency", int'(car.Go), 1);
      serve();
      chk("t1_pend_clr", int'(Pend), 0);
      chk("t1_go_drop", int'(car.Go), 0);
      // two cabin calls upward: nearest first
      I1 = 1; I2 = 1;
      tick(1);
      I1 = 0; I2 = 0;
      expect_go(2'd1, 1'b1);
      expect_go(2'd2, 1'b1);
      serve();
      serve();
      chk("t3_pend", int'(Pend), 0);
      // at floor 2: E0 during WAIT, E2 in the Done cycle is discarded
      S0 = 0; S2 = 1;
      E2 = 1;
      tick(1);
      E2 = 0;
      expect_go(2'd2, 1'b1);
      tick(2);
      E0 = 1;
      tick(1);
      E0 = 0;
      chk("t4_pend_wait", int'(Pend), 3'b101);
      expect_go(2'd0, 1'b0);
      car.Done = 1'b1; E2 = 1;
      tick(1);
      car.Done = 1'b0; E2 = 0;
      chk("t4_clear_wins", int'(Pend), 3'b001);
      serve();
      chk("t4_pend", int'(Pend), 0);
      // direction reversals
      S2 = 0; S0 = 1;
      I2 = 1;
      tick(1);
      I2 = 0;
      expect_go(2'd2, 1'b1);
      serve();
      S0 = 0; S1 = 1;
      I0 = 1;
      tick(1);
      I0 = 0;
      expect_go(2'd0, 1'b0);
      serve();
      // two sensors high: floor register holds 1
      S0 = 1;
      tick(2);
      I1 = 1;
      tick(1);
      I1 = 0;
      expect_go(2'd1, 1'b0);
      serve();
      // Done outside WAIT is ignored
      S0 = 0;
      I2 = 1;
      tick(1);
      I2 = 0;
      expect_go(2'd2, 1'b1);
      car.Done = 1'b1;
      tick(2);
      car.Done = 1'b0;
      chk("t7_go", int'(car.Go), 1);
      chk("t7_pend", int'(Pend), 3'b100);
      tick(1);
      chk("t7_go_wait", int'(car.Go), 1);
      serve();
      chk("t7_pend_clr", int'(Pend), 0);
      // async reset while waiting
      E0 = 1;
      tick(1);
      E0 = 0;
      expect_go(2'd0, 1'b0);
      tick(3);
      E2 = 1;
      tick(1);
      E2 = 0;
      chk("t8_go_wait", int'(car.Go), 1);
      #2 Reset = 1'b0;
      #1;
      chk("t8_rst_go", int'(car.Go), 0);
      chk("t8_rst_pend", int'(Pend), 0);
      chk("t8_rst_up", int'(car.Up), 1);
      tick(1);
      Reset = 1'b1;
      // door dwell
      car.DoorOpen = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick(1);
         chk($sformatf("dwell_edge%0d", i), int'(car.R), (i == 8) ? 1 : 0);
      end
      tick(3);
      chk("dwell_hold", int'(car.R), 1);
      car.DoorOpen = 1'b0;
      tick(1);
      chk("dwell_close", int'(car.R), 0);
      car.DoorOpen = 1'b1;
      tick(1);
      chk("dwell_reload", int'(car.R), 0);
      car.DoorOpen = 1'b0;
      tick(2);
      chk("sb_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
